// File: rtl/switch_selector_decoder.sv
// Stage switch-selector receiver: sync + glitch filter SS lines, latch address, verify word, fire channel pulse.
// Latency: address to BUSY 2+FILT_CYC cycles, VERIFY_DLY+1 more to VERIFY_VALID; read to CH_ACT 2+FILT_CYC cycles.
// No backpressure: inputs are level lines, sampled every cycle. Optional CH_ONEHOT output under SWSEL_ONEHOT_EN.

module switch_selector_filter #(
    parameter int W        = 1,
    parameter int FILT_CYC = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] filt
);
    localparam logic [7:0] FILT_LAST = 8'(FILT_CYC - 1);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [7:0]   cnt;
    logic [7:0]   cnt_nxt;

    // s1 is next cycle's s2, so a mismatch means the synchronised value is about to change.
    always_comb begin
        cnt_nxt = cnt;
        if (s1 != s2)
            cnt_nxt = 8'd0;
        else if (cnt != 8'hFF)
            cnt_nxt = cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            cnt  <= 8'd0;
            filt <= '0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            cnt <= cnt_nxt;
            if ((s1 == s2) && (cnt_nxt >= FILT_LAST))
                filt <= s2;
        end
    end
endmodule

module switch_selector_decoder #(
    parameter int FILT_CYC   = 4,
    parameter int VERIFY_DLY = 8,
    parameter int PULSE_CYC  = 16
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       SS1,
    input  logic       SS2,
    input  logic       SS3,
    input  logic       SS4,
    input  logic       SS5,
    input  logic       SS6,
    input  logic       SS7,
    input  logic       SS8,
    input  logic       SS14,
    input  logic       SS15,
    output logic [7:0] VERIFY,
    output logic       VERIFY_VALID,
    output logic       CH_ACT,
    output logic [7:0] CH_NUM,
    output logic       BUSY
`ifdef SWSEL_ONEHOT_EN
    ,
    output logic [255:0] CH_ONEHOT
`endif
);
    localparam logic [7:0]  VDLY       = 8'(VERIFY_DLY);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);

    typedef enum logic [1:0] {IDLE, ADDR, FIRE, HOLD} state_t;

    state_t      state;
    logic [7:0]  f_addr;
    logic        f_rd;
    logic        f_rst;
    logic        rd_q;
    logic        rd_rise;
    logic [7:0]  vcnt;
    logic [15:0] pcnt;

    switch_selector_filter #(.W(8), .FILT_CYC(FILT_CYC)) u_addr_filt (
        .clk   (SIM_CLK),
        .rst_n (SIM_RST),
        .raw   ({SS8, SS7, SS6, SS5, SS4, SS3, SS2, SS1}),
        .filt  (f_addr)
    );

    switch_selector_filter #(.W(1), .FILT_CYC(FILT_CYC)) u_rd_filt (
        .clk   (SIM_CLK),
        .rst_n (SIM_RST),
        .raw   (SS14),
        .filt  (f_rd)
    );

    switch_selector_filter #(.W(1), .FILT_CYC(FILT_CYC)) u_rst_filt (
        .clk   (SIM_CLK),
        .rst_n (SIM_RST),
        .raw   (SS15),
        .filt  (f_rst)
    );

    // Edge detect makes a held read fire at most once.
    assign rd_rise = f_rd & ~rd_q;

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state        <= IDLE;
            rd_q         <= 1'b0;
            vcnt         <= 8'd0;
            pcnt         <= 16'd0;
            VERIFY       <= 8'd0;
            VERIFY_VALID <= 1'b0;
            CH_ACT       <= 1'b0;
            CH_NUM       <= 8'd0;
            BUSY         <= 1'b0;
`ifdef SWSEL_ONEHOT_EN
            CH_ONEHOT    <= '0;
`endif
        end else begin
            rd_q <= f_rd;
            if (f_rst) begin
                state        <= IDLE;
                BUSY         <= 1'b0;
                CH_ACT       <= 1'b0;
                VERIFY       <= 8'd0;
                VERIFY_VALID <= 1'b0;
                vcnt         <= 8'd0;
                pcnt         <= 16'd0;
`ifdef SWSEL_ONEHOT_EN
                CH_ONEHOT    <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (f_addr != 8'd0) begin
                            CH_NUM <= f_addr;
                            vcnt   <= 8'd0;
                            state  <= ADDR;
                            BUSY   <= 1'b1;
                        end
                    end
                    ADDR: begin
                        if (rd_rise && VERIFY_VALID) begin
                            state  <= FIRE;
                            CH_ACT <= 1'b1;
                            pcnt   <= 16'd0;
`ifdef SWSEL_ONEHOT_EN
                            CH_ONEHOT <= 256'd1 << CH_NUM;
`endif
                        end else if ((f_addr != 8'd0) && (f_addr != CH_NUM)) begin
                            CH_NUM       <= f_addr;
                            vcnt         <= 8'd0;
                            VERIFY       <= 8'd0;
                            VERIFY_VALID <= 1'b0;
                        end else if (!VERIFY_VALID) begin
                            if (vcnt == VDLY) begin
                                VERIFY       <= ~CH_NUM;
                                VERIFY_VALID <= 1'b1;
                            end else begin
                                vcnt <= vcnt + 8'd1;
                            end
                        end
                    end
                    FIRE: begin
                        if (pcnt == PULSE_LAST) begin
                            CH_ACT <= 1'b0;
                            state  <= HOLD;
`ifdef SWSEL_ONEHOT_EN
                            CH_ONEHOT <= '0;
`endif
                        end else begin
                            pcnt <= pcnt + 16'd1;
                        end
                    end
                    HOLD: begin
                        if (!f_rd && (f_addr == 8'd0)) begin
                            state        <= IDLE;
                            BUSY         <= 1'b0;
                            VERIFY       <= 8'd0;
                            VERIFY_VALID <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_switch_selector_decoder.sv
// Directed bench for switch_selector_decoder at FILT_CYC=4, VERIFY_DLY=8, PULSE_CYC=16.
module tb_switch_selector_decoder;
    logic       SIM_CLK;
    logic       SIM_RST;
    logic       SS1, SS2, SS3, SS4, SS5, SS6, SS7, SS8, SS14, SS15;
    logic [7:0] VERIFY;
    logic       VERIFY_VALID;
    logic       CH_ACT;
    logic [7:0] CH_NUM;
    logic       BUSY;
`ifdef SWSEL_ONEHOT_EN
    logic [255:0] CH_ONEHOT;
    logic [255:0] exp_oh;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    switch_selector_decoder #(.FILT_CYC(4), .VERIFY_DLY(8), .PULSE_CYC(16)) dut (
        .SIM_CLK      (SIM_CLK),
        .SIM_RST      (SIM_RST),
        .SS1          (SS1),
        .SS2          (SS2),
        .SS3          (SS3),
        .SS4          (SS4),
        .SS5          (SS5),
        .SS6          (SS6),
        .SS7          (SS7),
        .SS8          (SS8),
        .SS14         (SS14),
        .SS15         (SS15),
        .VERIFY       (VERIFY),
        .VERIFY_VALID (VERIFY_VALID),
        .CH_ACT       (CH_ACT),
        .CH_NUM       (CH_NUM),
        .BUSY         (BUSY)
`ifdef SWSEL_ONEHOT_EN
        ,
        .CH_ONEHOT    (CH_ONEHOT)
`endif
    );

    initial SIM_CLK = 1'b0;
    always #5 SIM_CLK = ~SIM_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns 1 ns after the n-th rising edge, so samples and drives stay clear of the edge.
    task automatic tick(input int cycles);
        repeat (cycles) @(posedge SIM_CLK);
        #1;
    endtask

    task automatic set_addr(input logic [7:0] a);
        {SS8, SS7, SS6, SS5, SS4, SS3, SS2, SS1} = a;
    endtask

    task automatic count_act(input int cycles, output int c);
        c = 0;
        repeat (cycles) begin
            tick(1);
            if (CH_ACT) c++;
        end
    endtask

    initial begin
        SIM_RST = 1'b0;
        SS14 = 1'b0;
        SS15 = 1'b0;
        set_addr(8'h00);
        tick(3);
        chk("rst_busy", BUSY, 0);
        chk("rst_act", CH_ACT, 0);
        chk("rst_verify", VERIFY, 0);
        chk("rst_valid", VERIFY_VALID, 0);
        chk("rst_chnum", CH_NUM, 0);
        SIM_RST = 1'b1;
        tick(3);

        // Latch 0x5A and wait for the verify word
        set_addr(8'h5A);
        tick(5);
        chk("latch_busy_early", BUSY, 0);
        tick(1);
        chk("latch_busy", BUSY, 1);
        chk("latch_chnum", CH_NUM, 8'h5A);
        tick(8);
        chk("verify_early", VERIFY_VALID, 0);
        tick(1);
        chk("verify_valid", VERIFY_VALID, 1);
        chk("verify_word", VERIFY, 8'hA5);

        // 3-cycle read glitch must not fire
        SS14 = 1'b1;
        count_act(3, n);
        SS14 = 1'b0;
        begin
            int m;
            count_act(12, m);
            n += m;
        end
        chk("rd_glitch_act", n, 0);
        chk("rd_glitch_valid", VERIFY_VALID, 1);

        // Fire: exactly one 16-cycle pulse even with read held
        SS14 = 1'b1;
        tick(5);
        chk("fire_early", CH_ACT, 0);
        tick(1);
        chk("fire_act", CH_ACT, 1);
        chk("fire_chnum", CH_NUM, 8'h5A);
`ifdef SWSEL_ONEHOT_EN
        exp_oh = '0;
        exp_oh[8'h5A] = 1'b1;
        chk("onehot_on", (CH_ONEHOT === exp_oh), 1);
`endif
        count_act(40, n);
        chk("pulse_width", n + 1, 16);
        count_act(100, n);
        chk("no_refire", n, 0);
        chk("hold_busy", BUSY, 1);
`ifdef SWSEL_ONEHOT_EN
        chk("onehot_off", (CH_ONEHOT === 256'd0), 1);
`endif
        SS14 = 1'b0;
        set_addr(8'h00);
        tick(7);
        chk("idle_busy", BUSY, 0);
        chk("idle_valid", VERIFY_VALID, 0);
        chk("idle_verify", VERIFY, 0);
        chk("idle_chnum", CH_NUM, 8'h5A);

        // Address-bit glitch in IDLE
        set_addr(8'h04);
        tick(3);
        set_addr(8'h00);
        tick(12);
        chk("addr_glitch_busy", BUSY, 0);
        chk("addr_glitch_chnum", CH_NUM, 8'h5A);

        // Re-address before verify completes restarts the delay
        set_addr(8'h11);
        tick(6);
        chk("readdr_first", CH_NUM, 8'h11);
        set_addr(8'h22);
        tick(6);
        chk("readdr_chnum", CH_NUM, 8'h22);
        chk("readdr_valid0", VERIFY_VALID, 0);
        tick(8);
        chk("readdr_restart", VERIFY_VALID, 0);
        tick(1);
        chk("readdr_valid", VERIFY_VALID, 1);
        chk("readdr_verify", VERIFY, 8'hDD);

        // Early read (before verify) is ignored until re-toggled
        set_addr(8'h33);
        tick(2);
        SS14 = 1'b1;
        count_act(20, n);
        chk("early_rd_act", n, 0);
        chk("early_rd_valid", VERIFY_VALID, 1);
        chk("early_rd_verify", VERIFY, 8'hCC);
        SS14 = 1'b0;
        tick(8);
        SS14 = 1'b1;
        tick(5);
        chk("retoggle_early", CH_ACT, 0);
        tick(1);
        chk("retoggle_act", CH_ACT, 1);
        chk("retoggle_chnum", CH_NUM, 8'h33);

        // SS15 mid-pulse aborts to IDLE
        tick(3);
        SS15 = 1'b1;
        tick(5);
        chk("ss15_pre", CH_ACT, 1);
        tick(1);
        chk("ss15_act", CH_ACT, 0);
        chk("ss15_busy", BUSY, 0);
        chk("ss15_valid", VERIFY_VALID, 0);
        chk("ss15_verify", VERIFY, 0);
        tick(20);
        chk("ss15_stay_idle", BUSY, 0);
        SS15 = 1'b0;
        SS14 = 1'b0;
        set_addr(8'h00);
        tick(10);
        chk("ss15_release", BUSY, 0);

        // SS15 and SS14 together: no pulse, ever
        set_addr(8'h44);
        tick(16);
        chk("both_setup_valid", VERIFY_VALID, 1);
        chk("both_setup_verify", VERIFY, 8'hBB);
        SS15 = 1'b1;
        SS14 = 1'b1;
        count_act(10, n);
        chk("both_act", n, 0);
        chk("both_busy", BUSY, 0);
        SS15 = 1'b0;
        count_act(30, n);
        chk("both_after_act", n, 0);
        chk("both_after_valid", VERIFY_VALID, 1);

        // Asynchronous reset mid-pulse
        SS14 = 1'b0;
        tick(8);
        SS14 = 1'b1;
        tick(6);
        chk("arst_pulse", CH_ACT, 1);
        tick(4);
        #3;
        SIM_RST = 1'b0;
        #1;
        chk("arst_act", CH_ACT, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_chnum", CH_NUM, 0);
        chk("arst_verify", VERIFY, 0);
        chk("arst_valid", VERIFY_VALID, 0);
`ifdef SWSEL_ONEHOT_EN
        chk("arst_onehot", (CH_ONEHOT === 256'd0), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
